// File: rtl/fsqrt_dispatch.sv
// Front end of the FPU square-root core: classifies binary32 operands,
// resolves special values locally and runs the core start/done handshake.
module fsqrt_dispatch #(
    parameter int TIMEOUT = 64,
    parameter bit FTZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_operand,
    output logic        core_start,
    output logic [31:0] core_operand,
    input  logic        core_done,
    input  logic [31:0] core_result,
    input  logic        core_flag_nx,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_flag_nv,
    output logic        resp_flag_nx,
    output logic        resp_timeout
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CORE_WAIT = 2'd1;
    localparam logic [1:0] RESP      = 2'd2;

    localparam logic [31:0] CANON_NAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF      = 32'h7F80_0000;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] wait_count;
    logic        core_busy;
    logic        accept;

    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_frac;
    logic [22:0] eff_frac;
    logic        is_nan;
    logic        is_zero;
    logic        to_core;
    logic [31:0] special_result;
    logic        special_nv;

    // A core that has not yet answered still owns the datapath, so block new work.
    assign req_ready = rst & (state == IDLE) & ~core_busy;
    assign accept    = req_valid & req_ready;

    // Denormals are flushed before anything else so they classify as signed zero.
    always_comb begin
        op_sign  = req_operand[31];
        op_exp   = req_operand[30:23];
        op_frac  = req_operand[22:0];
        eff_frac = op_frac;
        if (FTZ && (op_exp == 8'h00)) begin
            eff_frac = 23'd0;
        end
        is_nan  = (op_exp == 8'hFF) && (eff_frac != 23'd0);
        is_zero = (op_exp == 8'h00) && (eff_frac == 23'd0);
    end

    always_comb begin
        to_core        = 1'b0;
        special_result = CANON_NAN;
        special_nv     = 1'b0;
        if (is_nan) begin
            special_nv = ~eff_frac[22];
        end else if (is_zero) begin
            special_result = {op_sign, 31'd0};
        end else if (op_sign) begin
            special_nv = 1'b1;
        end else if (op_exp == 8'hFF) begin
            special_result = POS_INF;
        end else begin
            to_core = 1'b1;
        end
    end

    // A done pulse always frees the core, even when it arrives after a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_busy <= 1'b0;
        end else if (core_done) begin
            core_busy <= 1'b0;
        end else if (core_start) begin
            core_busy <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wait_count   <= 16'd0;
            core_start   <= 1'b0;
            core_operand <= 32'd0;
            resp_valid   <= 1'b0;
            resp_result  <= 32'd0;
            resp_flag_nv <= 1'b0;
            resp_flag_nx <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (to_core) begin
                            core_operand <= req_operand;
                            core_start   <= 1'b1;
                            wait_count   <= 16'd0;
                            state        <= CORE_WAIT;
                        end else begin
                            resp_result  <= special_result;
                            resp_flag_nv <= special_nv;
                            resp_flag_nx <= 1'b0;
                            resp_timeout <= 1'b0;
                            resp_valid   <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                // core_done takes priority over a timeout landing in the same cycle.
                CORE_WAIT: begin
                    if (core_done) begin
                        resp_result  <= core_result;
                        resp_flag_nx <= core_flag_nx;
                        resp_flag_nv <= 1'b0;
                        resp_timeout <= 1'b0;
                        resp_valid   <= 1'b1;
                        wait_count   <= 16'd0;
                        state        <= RESP;
                    end else if (wait_count == TIMEOUT_LAST) begin
                        resp_result  <= CANON_NAN;
                        resp_flag_nx <= 1'b0;
                        resp_flag_nv <= 1'b0;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        wait_count   <= 16'd0;
                        state        <= RESP;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid   <= 1'b0;
                        resp_flag_nv <= 1'b0;
                        resp_flag_nx <= 1'b0;
                        resp_timeout <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsqrt_dispatch.sv
// Randomized bench for fsqrt_dispatch: a behavioural classifier plus a
// simple sqrt-core stand-in predict every response.
module tb_fsqrt_dispatch;

    localparam int TIMEOUT = 8;
    localparam logic [31:0] CANON = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_operand;
    logic        core_start, core_done, core_flag_nx;
    logic [31:0] core_operand, core_result;
    logic        resp_valid, resp_ready, resp_flag_nv, resp_flag_nx, resp_timeout;
    logic [31:0] resp_result;

    logic        r2_req_valid, r2_req_ready, r2_core_start, r2_core_done;
    logic [31:0] r2_req_operand, r2_core_operand, r2_core_result, r2_resp_result;
    logic        r2_resp_valid, r2_resp_ready, r2_nv, r2_nx, r2_to;

    int total = 0;
    int bad   = 0;

    int          start_count = 0;
    logic [31:0] start_operand = 32'd0;
    bit          core_respond = 1'b1;
    int          core_lat = 1;
    logic [31:0] core_res = 32'd0;
    bit          core_nx = 1'b0;
    bit          late_kick = 1'b0;
    logic [31:0] late_res = 32'h1234_5678;

    always #5 clk = ~clk;

    fsqrt_dispatch #(.TIMEOUT(TIMEOUT), .FTZ(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
        .core_start(core_start), .core_operand(core_operand),
        .core_done(core_done), .core_result(core_result), .core_flag_nx(core_flag_nx),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flag_nv(resp_flag_nv), .resp_flag_nx(resp_flag_nx), .resp_timeout(resp_timeout)
    );

    fsqrt_dispatch #(.TIMEOUT(TIMEOUT), .FTZ(1'b0)) dut_noftz (
        .clk(clk), .rst(rst),
        .req_valid(r2_req_valid), .req_ready(r2_req_ready), .req_operand(r2_req_operand),
        .core_start(r2_core_start), .core_operand(r2_core_operand),
        .core_done(r2_core_done), .core_result(r2_core_result), .core_flag_nx(1'b0),
        .resp_valid(r2_resp_valid), .resp_ready(r2_resp_ready), .resp_result(r2_resp_result),
        .resp_flag_nv(r2_nv), .resp_flag_nx(r2_nx), .resp_timeout(r2_to)
    );

    // Stand-in sqrt core: answers core_lat cycles after seeing core_start.
    initial begin
        int pend;
        pend = -1;
        core_done = 1'b0;
        core_result = 32'd0;
        core_flag_nx = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (!rst) begin
                pend = -1;
            end else begin
                if (late_kick) begin
                    core_done = 1'b1;
                    core_result = late_res;
                    core_flag_nx = 1'b1;
                    late_kick = 1'b0;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        core_done = 1'b1;
                        core_result = core_res;
                        core_flag_nx = core_nx;
                        pend = -1;
                    end
                end
                if (core_start && core_respond) pend = core_lat;
            end
        end
    end

    always @(negedge clk) begin
        if (core_start) begin
            start_count++;
            start_operand = core_operand;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // IEEE-754 sqrt front-end rules, evaluated from the field values.
    function automatic void refModel(input logic [31:0] op, input bit ftz,
                                     output bit to_core, output logic [31:0] res, output bit nv);
        logic       sign;
        logic [7:0] e;
        logic [22:0] f;
        sign = op[31];
        e = op[30:23];
        f = op[22:0];
        if (ftz && e == 8'd0) f = 23'd0;
        to_core = 1'b0;
        res = CANON;
        nv = 1'b0;
        if (e == 8'hFF && f != 0) nv = (f[22] == 1'b0);
        else if (e == 8'd0 && f == 0) res = {sign, 31'd0};
        else if (sign) nv = 1'b1;
        else if (e == 8'hFF) res = 32'h7F80_0000;
        else to_core = 1'b1;
    endfunction

    function automatic logic [31:0] randOperand();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        e = 8'($urandom_range(1, 254));
        case ($urandom_range(0, 8))
            0, 1, 2: return {1'b0, e, r[22:0]};
            3:       return {1'b1, e, r[22:0]};
            4:       return {r[31], 8'd0, r[22:1], 1'b1};
            5:       return {r[31], 31'd0};
            6:       return {r[31], 8'hFF, 23'd0};
            7:       return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            default: return {r[31], 8'hFF, 1'b1, r[21:0]};
        endcase
    endfunction

    task automatic waitReady();
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!req_ready) checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] op, input int lat, input bit respond,
                                 input int hold, input logic [31:0] cres, input bit cnx);
        bit          to_core, exp_nv, exp_nx, exp_to;
        logic [31:0] exp_res;
        int          n, exp_lat, starts_before;
        refModel(op, 1'b1, to_core, exp_res, exp_nv);
        exp_nx = 1'b0;
        exp_to = 1'b0;
        core_res = cres;
        core_nx = cnx;
        core_lat = lat;
        core_respond = respond;
        if (!to_core) exp_lat = 0;
        else if (respond) begin
            exp_lat = lat + 1;
            exp_res = cres;
            exp_nx = cnx;
        end else begin
            exp_lat = TIMEOUT;
            exp_res = CANON;
            exp_to = 1'b1;
        end
        waitReady();
        starts_before = start_count;
        req_operand = op;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < TIMEOUT + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("latency %h", op), 32'(n), 32'(exp_lat));
        checkOutput($sformatf("result %h", op), resp_result, exp_res);
        checkOutput($sformatf("nv %h", op), 32'(resp_flag_nv), 32'(exp_nv));
        checkOutput($sformatf("nx %h", op), 32'(resp_flag_nx), 32'(exp_nx));
        checkOutput($sformatf("timeout %h", op), 32'(resp_timeout), 32'(exp_to));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_result", resp_result, exp_res);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("valid_after_hs", 32'(resp_valid), 32'd0);
        checkOutput("flags_after_hs", {29'd0, resp_flag_nv, resp_flag_nx, resp_timeout}, 32'd0);
        if (respond) checkOutput("ready_after_hs", 32'(req_ready), 32'd1);
        checkOutput($sformatf("start_pulses %h", op), 32'(start_count - starts_before), 32'(to_core));
        if (to_core) checkOutput("core_operand", start_operand, op);
    endtask

    initial begin
        logic [31:0] specials [7];
        specials = '{32'hBF80_0000, 32'h7F80_0001, 32'h7FC0_0001, 32'h8000_0000,
                     32'h7F80_0000, 32'hFF80_0000, 32'h8000_0001};
        rst = 1'b0;
        req_valid = 1'b0;
        req_operand = 32'd0;
        resp_ready = 1'b0;
        r2_req_valid = 1'b0;
        r2_req_operand = 32'd0;
        r2_core_done = 1'b0;
        r2_core_result = 32'd0;
        r2_resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_core_start", 32'(core_start), 32'd0);
        checkOutput("rst_core_operand", core_operand, 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_result", resp_result, 32'd0);
        checkOutput("rst_flags", {29'd0, resp_flag_nv, resp_flag_nx, resp_timeout}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", 32'(req_ready), 32'd1);

        $display("[TB] core path 4.0 with backpressure");
        applyStimulus(32'h4080_0000, 5, 1'b1, 10, 32'h4000_0000, 1'b0);

        $display("[TB] special operands back to back");
        for (int i = 0; i < 7; i++) applyStimulus(specials[i], 1, 1'b1, 0, 32'd0, 1'b0);

        $display("[TB] randomized operands");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(randOperand(), int'($urandom_range(1, TIMEOUT - 1)), 1'b1,
                          int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] timeout then late core_done");
        applyStimulus(32'h4080_0000, 1, 1'b0, 2, 32'd0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("ready_while_busy", 32'(req_ready), 32'd0);
        end
        late_kick = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_late_done", 32'(req_ready), 32'd1);
        checkOutput("late_valid", 32'(resp_valid), 32'd0);
        checkOutput("late_result_leak", 32'(resp_result == late_res), 32'd0);
        core_respond = 1'b1;

        $display("[TB] FTZ disabled forwards denormal");
        r2_req_operand = 32'h0000_0001;
        r2_req_valid = 1'b1;
        @(posedge clk);
        #1;
        r2_req_valid = 1'b0;
        checkOutput("noftz_start", 32'(r2_core_start), 32'd1);
        checkOutput("noftz_operand", r2_core_operand, 32'h0000_0001);
        r2_core_result = 32'h1A3504F3;
        r2_core_done = 1'b1;
        @(posedge clk);
        #1;
        r2_core_done = 1'b0;
        checkOutput("noftz_valid", 32'(r2_resp_valid), 32'd1);
        checkOutput("noftz_result", r2_resp_result, 32'h1A3504F3);
        r2_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        r2_resp_ready = 1'b0;
        checkOutput("noftz_ready", 32'(r2_req_ready), 32'd1);

        $display("[TB] async reset while core_start is pending");
        core_lat = 3;
        waitReady();
        req_operand = 32'h4110_0000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("pre_rst_start", 32'(core_start), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_start", 32'(core_start), 32'd0);
        checkOutput("mid_rst_operand", core_operand, 32'd0);
        checkOutput("mid_rst_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("post_rst_no_resp", 32'(resp_valid), 32'd0);
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
        applyStimulus(32'h4110_0000, 3, 1'b1, 1, 32'h4040_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
